// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter
// ----------------
// Shares one slow line-memory port between NUM_CH cache refill/write-back
// channels (channel 0 = I-cache, 1 = D-cache by convention). Only one line
// transaction is outstanding at a time.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, arbitration is fixed priority (lowest channel index wins).
//
// Ports:
//   clk, proc_reset        clock (rising edge), async active-high reset
//   ch_read/ch_write       per-channel request flags, held until ch_ready
//   ch_addr/ch_wdata       flattened per-channel line address / write data
//   ch_rdata               flattened registered read data per channel
//   ch_ready               one-cycle completion pulse per channel
//   mem_read/mem_write     downstream level strobes, high only while BUSY
//   mem_addr/mem_wdata     downstream address / write data
//   mem_rdata/mem_ready    downstream read data and completion
//   dbg_state              current FSM state (IDLE=0, BUSY=1, RESP=2, RELEASE=3)
//
// Handshake: a channel raises ch_read and/or ch_write with stable addr/wdata
// and keeps them until it sees its ch_ready pulse. Downstream, the strobes
// stay high until mem_ready is seen high on a rising edge; mem_rdata is
// sampled on that same edge. mem_ready outside BUSY is ignored.
module line_mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 28,
    parameter int IDX_W  = 1
) (
    input  logic                     clk,
    input  logic                     proc_reset,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH*LINE_W-1:0] ch_rdata,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_CH-1:0]  req;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               win_rd;
    logic               win_wr;
    logic [ADDR_W-1:0]  win_addr;
    logic [LINE_W-1:0]  win_wdata;
    logic               grant;

    assign req   = ch_read | ch_write;
    assign grant = (state == S_IDLE) && (|req);

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin: the first requester strictly above the last winner wins;
    // if there is none, wrap around to the lowest-index requester.
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_any;

    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (i > int'(rr_ptr)) begin
                    hi_idx = IDX_W'(i);
                    hi_any = 1'b1;
                end
            end
        end
        grant_idx = hi_any ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            rr_ptr <= IDX_W'(NUM_CH - 1);
        end else if (grant) begin
            rr_ptr <= grant_idx;
        end
    end
`else
    // Fixed priority: scanning downwards leaves the lowest requester.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Winner capture and read-data return. Once granted, the downstream
    // port is driven purely from these registers, so channel inputs may
    // change freely during BUSY.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            win_idx   <= '0;
            win_rd    <= 1'b0;
            win_wr    <= 1'b0;
            win_addr  <= '0;
            win_wdata <= '0;
            ch_rdata  <= '0;
        end else begin
            if (grant) begin
                win_idx   <= grant_idx;
                win_rd    <= ch_read[grant_idx];
                win_wr    <= ch_write[grant_idx];
                win_addr  <= ch_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                win_wdata <= ch_wdata[int'(grant_idx)*LINE_W +: LINE_W];
            end
            if ((state == S_BUSY) && mem_ready && win_rd) begin
                ch_rdata[int'(win_idx)*LINE_W +: LINE_W] <= mem_rdata;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; RELEASE is a dead cycle letting the winner drop its
    // request before the next arbitration.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (|req) state_nxt = S_BUSY;
            S_BUSY:    if (mem_ready) state_nxt = S_RESP;
            S_RESP:    state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; decoded from the state register so reset clears them
    // immediately.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ch_ready  = '0;
        case (state)
            S_BUSY: begin
                mem_read  = win_rd;
                mem_write = win_wr;
                mem_addr  = win_addr;
                mem_wdata = win_wdata;
            end
            S_RESP: begin
                ch_ready[win_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
Arbitrates N cache line-refill/write-back channels onto one shared 128-bit slow-memory port. Sits between the I-cache/D-cache memory-side interfaces and a single external line memory. It generalises the current two-private-memory-port top level to a parametrised channel count. Requests are serialised: one line transaction is outstanding at a time, and each channel sees its own ready/rdata.

Parameters:
NUM_CH, 2, number of requesting channels (2..8); channel 0 = I-cache, 1 = D-cache by convention
LINE_W, 128, line data width in bits
ADDR_W, 28, line address width (byte address bits [31:4])
IDX_W, 1, width of channel index, must be >= clog2(NUM_CH)

Ports:
clk  input  1  clock, all state on rising edge
proc_reset  input  1  asynchronous active-high reset
ch_read  input  NUM_CH  per-channel line read request, held until that channel's ch_ready
ch_write  input  NUM_CH  per-channel line write request, held until that channel's ch_ready
ch_addr  input  NUM_CH*ADDR_W  flattened line addresses, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  input  NUM_CH*LINE_W  flattened write data
ch_rdata  output  NUM_CH*LINE_W  flattened registered read data
ch_ready  output  NUM_CH  one-cycle completion pulse per channel
mem_read  output  1  downstream read strobe
mem_write  output  1  downstream write strobe
mem_addr  output  ADDR_W  downstream line address
mem_wdata  output  LINE_W  downstream write data
mem_rdata  input  LINE_W  downstream read data, valid with mem_ready
mem_ready  input  1  downstream completion

Behaviour:
- Reset (async, any state): FSM=IDLE, all outputs 0, rr pointer = NUM_CH-1, any outstanding downstream transaction abandoned (strobes drop immediately).
- Channel i requesting = ch_read[i] | ch_write[i].
- FSM states: IDLE, BUSY, RESP, RELEASE.
- IDLE: if any channel requesting, select winner, latch its index, read/write flags, addr, wdata into registers; next state BUSY. None requesting -> stay.
- BUSY: mem_read/mem_write/mem_addr/mem_wdata driven from latched registers only (changes on ch_* ignored). On mem_ready=1: latch mem_rdata into winner's ch_rdata slice (reads only; writes leave rdata unchanged), next RESP.
- RESP: ch_ready[winner]=1 for exactly this cycle; downstream strobes 0; next RELEASE.
- RELEASE: one dead cycle so winner can drop its request; winner's request ignored; next IDLE.
- Latency: request visible at edge t -> strobes asserted from cycle t+1; mem_ready at cycle r -> ch_ready at r+1; next grant decision at r+3.
- Strobes asserted continuously in BUSY (level, not pulse); never asserted outside BUSY.
- ch_read and ch_write both high on one channel: forwarded as-is; downstream defines semantics.
- Non-winning channels: ch_ready stays 0, rdata slices hold previous values.
- mem_ready outside BUSY: ignored.
- Requests dropped by channel before grant: simply not selected; dropped during BUSY: transaction still completes and ready still pulses.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN. Defined: round-robin; search starts at (rr pointer + 1) mod NUM_CH, rr pointer updated to winner at grant; no channel waits more than NUM_CH-1 transactions. Undefined: fixed priority, lowest index wins; rr pointer not implemented.

Test Plan:
- Single read: ch_read[1]=1, ch_addr[1]=28'h0000123 -> mem_read=1, mem_addr=28'h0000123 next cycle; mem_ready with mem_rdata=128'hDEAD..BEEF -> ch_ready[1] pulse 1 cycle later, ch_rdata[1] equals it, ch_ready[0]=0.
- Single write: ch_write[0]=1, wdata=128'h0123..CDEF -> mem_write=1 with same data/addr until mem_ready; ch_rdata[0] unchanged after ch_ready[0].
- Simultaneous reads ch0 and ch1 held continuously, memory latency 5 cycles -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without, after ch0 completes ch1 served only once ch0 stops requesting.
- Input change during BUSY: ch_addr[0] altered mid-transaction -> mem_addr stays at latched value until mem_ready.
- proc_reset asserted mid-BUSY (asynchronously, between edges) -> mem_read/mem_write and ch_ready go 0 immediately; after release, held request re-issued from IDLE.
- NUM_CH=4, all four requesting, ARB_ROUND_ROBIN_EN -> grant order 0,1,2,3,0; each ch_ready exactly one cycle wide.
